config_logic_tile: RTL

// K-input LUT logic tile with optional output flop; parametrised successor of the fixed 5-input tile.

---
 rtl/config_logic_tile.sv | 111 +++++++++++
 1 files changed

// File: rtl/config_logic_tile.sv
// K-input LUT logic tile with optional output flop. Configuration arrives in CW-bit
// chunks into a shadow register and is committed atomically on the last beat.
module config_logic_tile #(
  parameter int K  = 5,
  parameter int CW = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [K-1:0]  in,
  input  logic          ce,
  output logic          out,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_ready,
  output logic          cfg_done,
  output logic          configured
);

  localparam int LUT_N = 2**K;
  localparam int CFG_W = LUT_N + 2;
  localparam int NB    = (CFG_W + CW - 1) / CW;
  localparam int CNT_W = $clog2(NB + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CFG_W-1:0]   shadow_q;
  logic [CFG_W-1:0]   shadow_d;
  logic [LUT_N-1:0]   lut_q;
  logic               reg_sel_q;
  logic               ff_q;
  logic               cfg_ready_q;
  logic               cfg_done_q;
  logic               configured_q;

  logic accept;
  logic last_beat;
  logic commit;
  logic lut_o;

  // Handshake: a chunk transfers on a rising edge where cfg_valid and cfg_ready are
  // both high; cfg_ready is high exactly while loading, and cfg_start overrides any beat.
  assign accept    = cfg_valid & cfg_ready_q;
  assign last_beat = (cnt_q == CNT_W'(NB - 1));
  assign commit    = accept & last_beat & ~cfg_start;

  // Bits of the current beat that fall at or above CFG_W simply have no destination.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < CFG_W; i++) begin
      if (cnt_q == CNT_W'(i / CW)) shadow_d[i] = cfg_data[i % CW];
    end
  end

  assign lut_o      = lut_q[in];
  assign out        = configured_q & (reg_sel_q ? ff_q : lut_o);
  assign cfg_ready  = cfg_ready_q;
  assign cfg_done   = cfg_done_q;
  assign configured = configured_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shadow_q     <= '0;
      lut_q        <= '0;
      reg_sel_q    <= 1'b0;
      ff_q         <= 1'b0;
      cfg_ready_q  <= 1'b0;
      cfg_done_q   <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      cfg_done_q <= 1'b0;
      if (configured_q & ce & ~commit) ff_q <= lut_o;

      if (cfg_start) begin
        state_q     <= S_LOAD;
        cfg_ready_q <= 1'b1;
        cnt_q       <= '0;
        shadow_q    <= '0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (accept) begin
              if (last_beat) begin
                state_q      <= S_RUN;
                cfg_ready_q  <= 1'b0;
                lut_q        <= shadow_d[LUT_N-1:0];
                reg_sel_q    <= shadow_d[LUT_N];
                ff_q         <= shadow_d[CFG_W-1];
                configured_q <= 1'b1;
                cfg_done_q   <= 1'b1;
              end else begin
                shadow_q <= shadow_d;
                cnt_q    <= cnt_q + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
